finalproj_soc_multitimer: RTL

FINALPROJ_SOC_MULTITIMER -- requirements
Module: finalproj_soc_multitimer

---
 rtl/finalproj_soc_multitimer_pkg.sv | 27 ++
 rtl/finalproj_soc_multitimer_ch.sv | 140 ++++++++++++++
 rtl/finalproj_soc_multitimer.sv | 69 ++++++
 3 files changed

// File: rtl/finalproj_soc_multitimer_pkg.sv
// Shared register map, bit indices and reset constants for the multitimer.
// Optional PWM support is enabled with FINALPROJ_SOC_MULTITIMER_PWM_EN.
package finalproj_soc_multitimer_pkg;

   typedef enum logic [2:0] {
      REG_STATUS  = 3'd0,
      REG_CONTROL = 3'd1,
      REG_PERIOD  = 3'd2,
      REG_SNAP    = 3'd3,
      REG_COMPARE = 3'd4,
      REG_PRESC   = 3'd5,
      REG_COUNT   = 3'd6,
      REG_RSVD    = 3'd7
   } reg_e;

   localparam int ST_TO  = 0;
   localparam int ST_RUN = 1;

   localparam int CTL_ITO    = 0;
   localparam int CTL_CONT   = 1;
   localparam int CTL_START  = 2;
   localparam int CTL_STOP   = 3;
   localparam int CTL_PWM_EN = 4;

   localparam logic [31:0] RST_PERIOD = 32'd49999;

endpackage

// File: rtl/finalproj_soc_multitimer_ch.sv
// One timer channel: prescaler, down counter, TO/RUN status and PWM.
// PWM/COMPARE exist only when FINALPROJ_SOC_MULTITIMER_PWM_EN is defined.
module finalproj_soc_multitimer_ch
   import finalproj_soc_multitimer_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter int PRESC_W = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        wr_en,
   input  logic [2:0]  reg_sel,
   input  logic [31:0] writedata,
   output logic [31:0] rd_data,
   output logic        irq_req,
   output logic        pwm
);

   localparam logic [CNT_W-1:0] CNT_RST = RST_PERIOD[CNT_W-1:0];

   logic               run;
   logic               to;
   logic               ito;
   logic               cont;
   logic [CNT_W-1:0]   period;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   snap;
   logic [PRESC_W-1:0] presc;
   logic [PRESC_W-1:0] pcnt;
   logic               tick;
   logic               timeout;
   reg_e               rsel;

   assign rsel    = reg_e'(reg_sel);
   assign tick    = run && (pcnt == '0);
   assign timeout = tick && (cnt == '0);
   assign irq_req = to & ito;

`ifdef FINALPROJ_SOC_MULTITIMER_PWM_EN
   logic             pwm_en;
   logic [CNT_W-1:0] compare;
   logic             pwm_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pwm_en  <= 1'b0;
         compare <= '0;
         pwm_q   <= 1'b0;
      end else begin
         pwm_q <= run & pwm_en & (cnt < compare);
         if (wr_en && rsel == REG_CONTROL)
            pwm_en <= writedata[CTL_PWM_EN];
         if (wr_en && rsel == REG_COMPARE)
            compare <= writedata[CNT_W-1:0];
      end
   end

   assign pwm = pwm_q;
`else
   assign pwm = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         run    <= 1'b0;
         to     <= 1'b0;
         ito    <= 1'b0;
         cont   <= 1'b0;
         period <= CNT_RST;
         cnt    <= CNT_RST;
         snap   <= '0;
         presc  <= '0;
         pcnt   <= '0;
      end else begin
         if (run)
            pcnt <= (pcnt == '0) ? presc : pcnt - PRESC_W'(1);
         if (tick)
            cnt <= (cnt == '0) ? period : cnt - CNT_W'(1);
         if (timeout) begin
            to <= 1'b1;
            if (!cont)
               run <= 1'b0;
         end
         // Register writes come last so an explicit command beats
         // the autonomous counter update in the same cycle.
         if (wr_en) begin
            unique case (rsel)
               REG_STATUS: begin
                  if (!timeout)
                     to <= 1'b0;
               end
               REG_CONTROL: begin
                  ito  <= writedata[CTL_ITO];
                  cont <= writedata[CTL_CONT];
                  if (writedata[CTL_START]) begin
                     run  <= 1'b1;
                     pcnt <= presc;
                  end else if (writedata[CTL_STOP]) begin
                     run <= 1'b0;
                  end
               end
               REG_PERIOD: begin
                  period <= writedata[CNT_W-1:0];
                  cnt    <= writedata[CNT_W-1:0];
                  run    <= 1'b0;
               end
               REG_SNAP:  snap  <= cnt;
               REG_PRESC: presc <= writedata[PRESC_W-1:0];
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      rd_data = '0;
      unique case (rsel)
         REG_STATUS: begin
            rd_data[ST_RUN] = run;
            rd_data[ST_TO]  = to;
         end
         REG_CONTROL: begin
            rd_data[CTL_ITO]  = ito;
            rd_data[CTL_CONT] = cont;
`ifdef FINALPROJ_SOC_MULTITIMER_PWM_EN
            rd_data[CTL_PWM_EN] = pwm_en;
`endif
         end
         REG_PERIOD: rd_data[CNT_W-1:0] = period;
         REG_SNAP:   rd_data[CNT_W-1:0] = snap;
`ifdef FINALPROJ_SOC_MULTITIMER_PWM_EN
         REG_COMPARE: rd_data[CNT_W-1:0] = compare;
`endif
         REG_PRESC:  rd_data[PRESC_W-1:0] = presc;
         REG_COUNT:  rd_data[CNT_W-1:0] = cnt;
         default: ;
      endcase
   end

endmodule

// File: rtl/finalproj_soc_multitimer.sv
// Multi-channel timer: address decode, registered read mux and irq OR.
// Define FINALPROJ_SOC_MULTITIMER_PWM_EN to build per-channel PWM outputs.
module finalproj_soc_multitimer
   import finalproj_soc_multitimer_pkg::*;
#(
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 32,
   parameter int PRESC_W = 16
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [$clog2(NUM_CH)+2:0]   address,
   input  logic                        chipselect,
   input  logic                        write_n,
   input  logic [31:0]                 writedata,
   output logic [31:0]                 readdata,
   output logic                        irq,
   output logic [NUM_CH-1:0]           pwm_out
);

   localparam int AW = $clog2(NUM_CH) + 3;

   logic [7:0]        addr_ext;
   logic [4:0]        ch_idx;
   logic [2:0]        reg_sel;
   logic              wr;
   logic [31:0]       ch_rd [NUM_CH];
   logic [NUM_CH-1:0] irq_vec;
   logic [31:0]       rd_next;

   // Zero-extend so a single-channel build still decodes channel 0.
   assign addr_ext = 8'(address);
   assign ch_idx   = addr_ext[7:3];
   assign reg_sel  = addr_ext[2:0];
   assign wr       = chipselect & ~write_n;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      finalproj_soc_multitimer_ch #(
         .CNT_W   (CNT_W),
         .PRESC_W (PRESC_W)
      ) u_ch (
         .clk       (clk),
         .reset_n   (reset_n),
         .wr_en     (wr && (ch_idx == 5'(i))),
         .reg_sel   (reg_sel),
         .writedata (writedata),
         .rd_data   (ch_rd[i]),
         .irq_req   (irq_vec[i]),
         .pwm       (pwm_out[i])
      );
   end

   always_comb begin
      rd_next = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (ch_idx == 5'(i))
            rd_next = ch_rd[i];
   end

   always_ff @(posedge clk) begin
      if (!reset_n)
         readdata <= '0;
      else
         readdata <= rd_next;
   end

   assign irq = |irq_vec;

endmodule
